// File: rtl/match_persistence_filter.sv
// Debounces the comparator's per-sample equal flag into a stable match status
// with hysteresis. It emits one-cycle rise/fall pulses and keeps a saturating
// count of lock entries.
module match_persistence_filter #(
    parameter int ON_COUNT  = 4,
    parameter int OFF_COUNT = 2,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic             equal_in,
    output logic             match_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] run_count,
    output logic [7:0]       lock_events
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_C  = CNT_W'(ON_COUNT);
    localparam logic [CNT_W-1:0] OFF_C = CNT_W'(OFF_COUNT);

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_run,    w_run_nxt;
    logic             r_stable, w_stable_nxt;
    logic             r_rise,   w_rise_nxt;
    logic             r_fall,   w_fall_nxt;
    logic [7:0]       r_lock,   w_lock_nxt;
    logic [CNT_W-1:0] w_run_inc;
    logic [7:0]       w_lock_inc;

    // run_count is bounded by max(ON,OFF)-1, so the increment never wraps.
    assign w_run_inc  = r_run + CNT_W'(1);
    assign w_lock_inc = (r_lock == 8'hFF) ? r_lock : r_lock + 8'd1;

    // Next-state and next-output decode for the hysteresis FSM.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_stable_nxt = r_stable;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_lock_nxt   = r_lock;

        if (clear) begin
            w_state_nxt  = IDLE;
            w_run_nxt    = '0;
            w_stable_nxt = 1'b0;
            w_lock_nxt   = 8'd0;
        end else if (sample_valid) begin
            // equal_in is only looked at under sample_valid, so an X on it cannot leak.
            case (r_state)
                IDLE: begin
                    if (equal_in) begin
                        if (ON_COUNT == 1) begin
                            w_state_nxt  = LOCKED;
                            w_run_nxt    = '0;
                            w_stable_nxt = 1'b1;
                            w_rise_nxt   = 1'b1;
                            w_lock_nxt   = w_lock_inc;
                        end else begin
                            w_state_nxt = CONFIRM;
                            w_run_nxt   = CNT_W'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                CONFIRM: begin
                    if (equal_in) begin
                        if (w_run_inc == ON_C) begin
                            w_state_nxt  = LOCKED;
                            w_run_nxt    = '0;
                            w_stable_nxt = 1'b1;
                            w_rise_nxt   = 1'b1;
                            w_lock_nxt   = w_lock_inc;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_run_nxt   = '0;
                    end
                end
                LOCKED: begin
                    if (!equal_in) begin
                        if (OFF_COUNT == 1) begin
                            w_state_nxt  = IDLE;
                            w_run_nxt    = '0;
                            w_stable_nxt = 1'b0;
                            w_fall_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_run_nxt   = CNT_W'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                RELEASE: begin
                    if (!equal_in) begin
                        if (w_run_inc == OFF_C) begin
                            w_state_nxt  = IDLE;
                            w_run_nxt    = '0;
                            w_stable_nxt = 1'b0;
                            w_fall_nxt   = 1'b1;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; async reset drops everything with no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_lock   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_lock   <= w_lock_nxt;
        end
    end

    assign state        = r_state;
    assign run_count    = r_run;
    assign match_stable = r_stable;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign lock_events  = r_lock;

endmodule

// File: tb/tb_match_persistence_filter.sv
// Self-checking bench for match_persistence_filter. Two instances share the
// same stimulus: the default one (ON=4, OFF=2) and a single-sample one (ON=1, OFF=1).
// A counter-and-flag reference model predicts every registered output.
module tb_match_persistence_filter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic sample_valid = 1'b0;
    logic equal_in = 1'b0;

    logic       a_stable, a_rise, a_fall;
    logic [1:0] a_state;
    logic [3:0] a_run;
    logic [7:0] a_lock;
    logic       b_stable, b_rise, b_fall;
    logic [1:0] b_state;
    logic [3:0] b_run;
    logic [7:0] b_lock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit stable;
        int run;
        int lock;
        bit rise;
        bit fall;
    } model_t;

    model_t ma, mb;

    always #5 clk = ~clk;

    match_persistence_filter #(.ON_COUNT(4), .OFF_COUNT(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid), .equal_in(equal_in),
        .match_stable(a_stable), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .state(a_state), .run_count(a_run), .lock_events(a_lock)
    );

    match_persistence_filter #(.ON_COUNT(1), .OFF_COUNT(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid), .equal_in(equal_in),
        .match_stable(b_stable), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .state(b_state), .run_count(b_run), .lock_events(b_lock)
    );

    function automatic model_t model_reset();
        model_t m;
        m.stable = 0; m.run = 0; m.lock = 0; m.rise = 0; m.fall = 0;
        return m;
    endfunction

    // Streak counting: a run of agreeing samples long enough flips the status.
    function automatic model_t model_next(model_t s, bit clr, bit v, bit e, int on_n, int off_n);
        model_t m = s;
        m.rise = 0;
        m.fall = 0;
        if (clr) return model_reset();
        if (!v) return m;
        if (!m.stable) begin
            if (e) begin
                m.run++;
                if (m.run == on_n) begin
                    m.stable = 1; m.run = 0; m.rise = 1;
                    if (m.lock < 255) m.lock++;
                end
            end else m.run = 0;
        end else begin
            if (!e) begin
                m.run++;
                if (m.run == off_n) begin
                    m.stable = 0; m.run = 0; m.fall = 1;
                end
            end else m.run = 0;
        end
        return m;
    endfunction

    // State code from status plus whether a streak is in progress.
    function automatic logic [31:0] model_state(model_t m);
        return {30'd0, m.stable, (m.run != 0)};
    endfunction

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, " a.state"},  {30'd0, a_state},  model_state(ma));
        check({tag, " a.run"},    {28'd0, a_run},    ma.run);
        check({tag, " a.stable"}, {31'd0, a_stable}, ma.stable);
        check({tag, " a.rise"},   {31'd0, a_rise},   ma.rise);
        check({tag, " a.fall"},   {31'd0, a_fall},   ma.fall);
        check({tag, " a.lock"},   {24'd0, a_lock},   ma.lock);
        check({tag, " b.state"},  {30'd0, b_state},  model_state(mb));
        check({tag, " b.run"},    {28'd0, b_run},    mb.run);
        check({tag, " b.stable"}, {31'd0, b_stable}, mb.stable);
        check({tag, " b.rise"},   {31'd0, b_rise},   mb.rise);
        check({tag, " b.fall"},   {31'd0, b_fall},   mb.fall);
        check({tag, " b.lock"},   {24'd0, b_lock},   mb.lock);
    endtask

    // One clock: drive on the falling edge, then check 1 time unit after the rising edge.
    task automatic step(string tag, bit clr, bit v, logic e);
        @(negedge clk);
        clear = clr;
        sample_valid = v;
        equal_in = e;
        @(posedge clk);
        ma = model_next(ma, clr, v, (e === 1'b1), 4, 2);
        mb = model_next(mb, clr, v, (e === 1'b1), 1, 1);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] r;
        ma = model_reset();
        mb = model_reset();

        // Power-on reset.
        rst = 1'b1;
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step("idle", 0, 0, 0);

        // Four matches lock the default instance.
        repeat (4) step("lock4", 0, 1, 1);
        check({"lock4 state"}, {30'd0, a_state}, 32'd2);
        check({"lock4 rise"},  {31'd0, a_rise},  32'd1);
        step("lock4_hold", 0, 1, 1);

        // An interrupted run does not lock; a full run does.
        step("clr0", 1, 0, 0);
        repeat (3) step("run3", 0, 1, 1);
        step("break", 0, 1, 0);
        check("break state", {30'd0, a_state}, 32'd0);
        repeat (4) step("run4", 0, 1, 1);

        // Release pattern 0,1,0,0 from LOCKED.
        step("rel0", 0, 1, 0);
        step("rel1", 0, 1, 1);
        step("rel2", 0, 1, 0);
        step("rel3", 0, 1, 0);
        check("rel fall", {31'd0, a_fall}, 32'd1);

        // Gapped samples; X or 0 on equal_in during gaps is ignored.
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) step("gap_v", 0, 1, 1);
            else step("gap_x", 0, 0, (i == 3) ? 1'b0 : 1'bx);
        end

        // Saturate lock_events with 256 lock/unlock cycles.
        step("sat_clr", 1, 0, 0);
        for (int n = 0; n < 256; n++) begin
            repeat (4) step("sat_on", 0, 1, 1);
            repeat (2) step("sat_off", 0, 1, 0);
        end
        check("sat lock", {24'd0, a_lock}, 32'd255);
        repeat (4) step("sat_relock", 0, 1, 1);

        // Clear out of LOCKED raises no pulse.
        step("clr_locked", 1, 1, 0);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            r = 2'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 40) == 0), (r != 0), logic'($urandom_range(0, 1)));
        end

        // Async reset mid-confirm acts without a clock edge.
        step("pre_rst", 1, 0, 0);
        repeat (2) step("confirm", 0, 1, 1);
        #2;
        rst = 1'b1;
        ma = model_reset();
        mb = model_reset();
        #1;
        check_all("async_rst");
        rst = 1'b0;
        step("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
